// File: rtl/regfile_pkg.sv
// Shared constants and types for the two-read/one-write register file.
package regfile_pkg;

    // Default geometry: 8 registers of 16 bits.
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;
    localparam int NREGS      = 2 ** ADDR_W_DEF;

    // Register index and data types for the default geometry.
    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard: one flag per register marking a pending producer.
// A reserve and a write-clear that land on the same index in one cycle
// resolve with the reserve winning, because the newer producer is still
// outstanding. Reset clears every flag and overrides both.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_idx_i,
    input  logic              clr_en_i,
    input  logic [ADDR_W-1:0] clr_idx_i,
    input  logic [ADDR_W-1:0] look_a_i,
    input  logic [ADDR_W-1:0] look_b_i,
    output logic              busy_a_o,
    output logic              busy_b_o
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Next-state flags: clear for the completing write first, then set for
    // the new reservation so the reservation has the final say.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_idx_i] = 1'b0;
        end
        if (set_en_i) begin
            busy_d[set_idx_i] = 1'b1;
        end
        if (ZERO_R0) begin
            busy_d[0] = 1'b0;
        end
    end

    // Flag register with synchronous reset taking priority over set/clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Lookup ports report the stored flag; bypass masking is done by the caller.
    assign busy_a_o = busy_q[look_a_i];
    assign busy_b_o = busy_q[look_b_i];

endmodule

// File: rtl/regfile_2r1w_sb.sv
// Register file with one synchronous write port, two combinational read
// ports, optional write-to-read bypass and a per-register busy scoreboard
// used by the controller to detect read-after-write hazards.
module regfile_2r1w_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] writenum,
    input  logic              write,
    input  logic              reserve,
    input  logic [ADDR_W-1:0] reservenum,
    input  logic [ADDR_W-1:0] readnum_a,
    input  logic [ADDR_W-1:0] readnum_b,
    output logic [DATA_W-1:0] data_out_a,
    output logic [DATA_W-1:0] data_out_b,
    output logic              busy_a,
    output logic              busy_b
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic wr_en;
    logic rsv_en;
    logic hit_a;
    logic hit_b;
    logic rd_zero_a;
    logic rd_zero_b;
    logic sb_busy_a;
    logic sb_busy_b;

    // Effective write/reserve enables: register 0 swallows both when hardwired.
    always_comb begin
        wr_en  = write;
        rsv_en = reserve;
        if (ZERO_R0 && (writenum == '0)) begin
            wr_en = 1'b0;
        end
        if (ZERO_R0 && (reservenum == '0)) begin
            rsv_en = 1'b0;
        end
    end

    // Data array: synchronous clear on reset, otherwise a single indexed write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[writenum] <= data_in;
        end
    end

    rf_scoreboard #(
        .ADDR_W  (ADDR_W),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_en_i  (rsv_en),
        .set_idx_i (reservenum),
        .clr_en_i  (wr_en),
        .clr_idx_i (writenum),
        .look_a_i  (readnum_a),
        .look_b_i  (readnum_b),
        .busy_a_o  (sb_busy_a),
        .busy_b_o  (sb_busy_b)
    );

    // Per-port bypass hit and hardwired-zero detection.
    always_comb begin
        hit_a     = BYPASS && write && (writenum == readnum_a);
        hit_b     = BYPASS && write && (writenum == readnum_b);
        rd_zero_a = ZERO_R0 && (readnum_a == '0);
        rd_zero_b = ZERO_R0 && (readnum_b == '0);
    end

    // Port A: binary-indexed read, bypassed value counts as available.
    always_comb begin
        data_out_a = hit_a ? data_in : regs_q[readnum_a];
        busy_a     = sb_busy_a && !hit_a;
        if (rd_zero_a) begin
            data_out_a = '0;
            busy_a     = 1'b0;
        end
    end

    // Port B: same resolution as port A, evaluated independently.
    always_comb begin
        data_out_b = hit_b ? data_in : regs_q[readnum_b];
        busy_b     = sb_busy_b && !hit_b;
        if (rd_zero_b) begin
            data_out_b = '0;
            busy_b     = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Bench for regfile_2r1w_sb: three instances share inputs
// (0: BYPASS=1 ZERO_R0=0, 1: BYPASS=0 ZERO_R0=0, 2: BYPASS=1 ZERO_R0=1)
// and are compared against an array-based reference model.
module tb_regfile_2r1w_sb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data_in = '0;
    logic [2:0]  writenum = '0;
    logic        write = 1'b0;
    logic        reserve = 1'b0;
    logic [2:0]  reservenum = '0;
    logic [2:0]  readnum_a = '0;
    logic [2:0]  readnum_b = '0;

    logic [15:0] doa [3];
    logic [15:0] dob [3];
    logic        boa [3];
    logic        bob [3];

    logic [15:0] m_reg  [3][8];
    logic        m_busy [3][8];

    int passed = 0;
    int total  = 0;

    always #20 clk = ~clk;

    regfile_2r1w_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut0 (
        .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum), .write(write),
        .reserve(reserve), .reservenum(reservenum), .readnum_a(readnum_a), .readnum_b(readnum_b),
        .data_out_a(doa[0]), .data_out_b(dob[0]), .busy_a(boa[0]), .busy_b(bob[0]));

    regfile_2r1w_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b0), .ZERO_R0(1'b0)) dut1 (
        .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum), .write(write),
        .reserve(reserve), .reservenum(reservenum), .readnum_a(readnum_a), .readnum_b(readnum_b),
        .data_out_a(doa[1]), .data_out_b(dob[1]), .busy_a(boa[1]), .busy_b(bob[1]));

    regfile_2r1w_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b1), .ZERO_R0(1'b1)) dut2 (
        .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum), .write(write),
        .reserve(reserve), .reservenum(reservenum), .readnum_a(readnum_a), .readnum_b(readnum_b),
        .data_out_a(doa[2]), .data_out_b(dob[2]), .busy_a(boa[2]), .busy_b(bob[2]));

    function automatic bit byp(int k);
        return (k != 1);
    endfunction

    function automatic bit zr(int k);
        return (k == 2);
    endfunction

    // Expected read data for instance k at index idx under the current inputs.
    function automatic logic [15:0] exp_data(int k, logic [2:0] idx);
        if (zr(k) && idx == 3'd0) return 16'h0000;
        if (byp(k) && write && writenum == idx) return data_in;
        return m_reg[k][idx];
    endfunction

    function automatic logic exp_busy(int k, logic [2:0] idx);
        if (zr(k) && idx == 3'd0) return 1'b0;
        if (byp(k) && write && writenum == idx) return 1'b0;
        return m_busy[k][idx];
    endfunction

    // Advance one clock edge and update the model from the inputs seen there.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                for (int i = 0; i < 8; i++) begin
                    m_reg[k][i]  = 16'h0000;
                    m_busy[k][i] = 1'b0;
                end
            end else begin
                if (write && !(zr(k) && writenum == 3'd0)) begin
                    m_reg[k][writenum]  = data_in;
                    m_busy[k][writenum] = 1'b0;
                end
                if (reserve && !(zr(k) && reservenum == 3'd0)) begin
                    m_busy[k][reservenum] = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; write = 1'b0; reserve = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; write = 1'b1; writenum = 3'd4; data_in = 16'hDEAD;
        reserve = 1'b1; reservenum = 3'd4;
        tick();
        idle();
        for (int i = 0; i < 8; i++) begin
            readnum_a = 3'(i);
            readnum_b = 3'(7 - i);
            #1;
            for (int k = 0; k < 3; k++) begin
                total++;
                if (doa[k] !== 16'h0000 || dob[k] !== 16'h0000 || boa[k] !== 1'b0 || bob[k] !== 1'b0)
                    $display("FAIL reset_read inst%0d idx%0d: got a=%h b=%h ba=%b bb=%b want all zero",
                             k, i, doa[k], dob[k], boa[k], bob[k]);
                else passed++;
            end
        end
    endtask

    task automatic test_write_read();
        write = 1'b1; writenum = 3'd3; data_in = 16'hBEEF; readnum_a = 3'd3; readnum_b = 3'd0;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (doa[k] !== (byp(k) ? 16'hBEEF : 16'h0000))
                $display("FAIL write_cycle_bypass inst%0d: got %h want %h", k, doa[k],
                         byp(k) ? 16'hBEEF : 16'h0000);
            else passed++;
        end
        tick();
        idle();
        readnum_a = 3'd3; readnum_b = 3'd3;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (doa[k] !== 16'hBEEF || dob[k] !== 16'hBEEF)
                $display("FAIL write_then_read inst%0d: got a=%h b=%h want BEEF", k, doa[k], dob[k]);
            else passed++;
        end
    endtask

    task automatic test_reserve();
        reserve = 1'b1; reservenum = 3'd5;
        tick();
        idle();
        readnum_b = 3'd5;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (bob[k] !== 1'b1) $display("FAIL reserve_busy inst%0d: got %b want 1", k, bob[k]);
            else passed++;
        end
        write = 1'b1; writenum = 3'd5; data_in = 16'h1234;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (bob[k] !== (byp(k) ? 1'b0 : 1'b1) || dob[k] !== (byp(k) ? 16'h1234 : 16'h0000))
                $display("FAIL reserve_bypass inst%0d: got busy=%b data=%h want busy=%b data=%h",
                         k, bob[k], dob[k], !byp(k), byp(k) ? 16'h1234 : 16'h0000);
            else passed++;
        end
        tick();
        idle();
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (bob[k] !== 1'b0 || dob[k] !== 16'h1234)
                $display("FAIL reserve_cleared inst%0d: got busy=%b data=%h want 0/1234", k, bob[k], dob[k]);
            else passed++;
        end
    endtask

    task automatic test_same_cycle();
        reserve = 1'b1; reservenum = 3'd2; write = 1'b1; writenum = 3'd2; data_in = 16'h00AA;
        tick();
        idle();
        readnum_a = 3'd2;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (doa[k] !== 16'h00AA || boa[k] !== 1'b1)
                $display("FAIL same_cycle inst%0d: got data=%h busy=%b want 00AA/1", k, doa[k], boa[k]);
            else passed++;
        end
    endtask

    task automatic test_reset_override();
        write = 1'b1; writenum = 3'd6; data_in = 16'h5555;
        tick();
        writenum = 3'd7;
        tick();
        reset = 1'b1; write = 1'b1; writenum = 3'd6; data_in = 16'hFFFF;
        reserve = 1'b1; reservenum = 3'd4;
        tick();
        idle();
        readnum_a = 3'd6; readnum_b = 3'd7;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (doa[k] !== 16'h0000 || dob[k] !== 16'h0000)
                $display("FAIL reset_override_data inst%0d: got r6=%h r7=%h want 0000", k, doa[k], dob[k]);
            else passed++;
        end
        for (int i = 0; i < 8; i++) begin
            readnum_a = 3'(i);
            #1;
            for (int k = 0; k < 3; k++) begin
                total++;
                if (boa[k] !== 1'b0)
                    $display("FAIL reset_override_busy inst%0d idx%0d: got %b want 0", k, i, boa[k]);
                else passed++;
            end
        end
    endtask

    task automatic test_zero_r0();
        write = 1'b1; writenum = 3'd0; data_in = 16'h7777;
        reserve = 1'b1; reservenum = 3'd0; readnum_a = 3'd0;
        #1;
        total++;
        if (doa[2] !== 16'h0000 || boa[2] !== 1'b0)
            $display("FAIL zero_r0_write_cycle: got data=%h busy=%b want 0000/0", doa[2], boa[2]);
        else passed++;
        total++;
        if (doa[0] !== 16'h7777)
            $display("FAIL r0_bypass_normal: got %h want 7777", doa[0]);
        else passed++;
        tick();
        idle();
        #1;
        total++;
        if (doa[2] !== 16'h0000 || boa[2] !== 1'b0)
            $display("FAIL zero_r0_after: got data=%h busy=%b want 0000/0", doa[2], boa[2]);
        else passed++;
        total++;
        if (doa[0] !== 16'h7777 || boa[0] !== 1'b1)
            $display("FAIL r0_normal_after: got data=%h busy=%b want 7777/1", doa[0], boa[0]);
        else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 39) == 0);
            write      = $urandom_range(0, 1) == 1;
            writenum   = 3'($urandom_range(0, 7));
            data_in    = 16'($urandom);
            reserve    = $urandom_range(0, 2) == 0;
            reservenum = ($urandom_range(0, 3) == 0) ? writenum : 3'($urandom_range(0, 7));
            readnum_a  = ($urandom_range(0, 3) == 0) ? writenum : 3'($urandom_range(0, 7));
            readnum_b  = ($urandom_range(0, 3) == 0) ? readnum_a : 3'($urandom_range(0, 7));
            #1;
            for (int k = 0; k < 3; k++) begin
                total++;
                if (doa[k] !== exp_data(k, readnum_a) || boa[k] !== exp_busy(k, readnum_a) ||
                    dob[k] !== exp_data(k, readnum_b) || bob[k] !== exp_busy(k, readnum_b))
                    $display("FAIL random n%0d inst%0d: got a=%h/%b b=%h/%b want a=%h/%b b=%h/%b",
                             n, k, doa[k], boa[k], dob[k], bob[k],
                             exp_data(k, readnum_a), exp_busy(k, readnum_a),
                             exp_data(k, readnum_b), exp_busy(k, readnum_b));
                else passed++;
            end
            tick();
        end
        idle();
    endtask

    initial begin
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 8; i++) begin
                m_reg[k][i]  = 16'h0000;
                m_busy[k][i] = 1'b0;
            end
        @(negedge clk);
        test_reset();
        test_write_read();
        test_reserve();
        test_same_cycle();
        test_reset_override();
        test_zero_r0();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w_sb.md
Name: regfile_2r1w_sb

Overview:
Parametrised successor to the single-read-port 8x16 register file. It provides one synchronous write port and two combinational read ports (A and B), with an optional write-to-read bypass. A per-register busy scoreboard lets the controller mark a destination register as pending and stall on a read-after-write hazard. The block sits in the datapath between the writeback mux and the A/B operand latches.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, register index width; register count NREGS = 2**ADDR_W
BYPASS, 1, 1 = a read of the register being written this cycle returns data_in; 0 = returns the stored value
ZERO_R0, 0, 1 = register 0 is hardwired to zero, never busy, and ignores writes and reserves

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-high; sampled on rising clk
data_in  input  DATA_W  write data
writenum  input  ADDR_W  write register index
write  input  1  write enable
reserve  input  1  mark register reservenum as busy (pending producer)
reservenum  input  ADDR_W  index to reserve
readnum_a  input  ADDR_W  read port A index
readnum_b  input  ADDR_W  read port B index
data_out_a  output  DATA_W  port A data (combinational)
data_out_b  output  DATA_W  port B data (combinational)
busy_a  output  1  register readnum_a has a pending write
busy_b  output  1  register readnum_b has a pending write

Behaviour:
- Reset: on a rising clk with reset=1, all NREGS registers go to 0 and all busy bits go to 0. Reset overrides write and reserve in the same cycle. After the reset edge, all data_out are 0 and all busy outputs are 0.
- Write: on a rising clk with reset=0 and write=1, reg[writenum] <= data_in. The write clears busy[writenum]. Latency is 1 edge for the stored value.
- Reserve: on a rising clk with reset=0 and reserve=1, busy[reservenum] <= 1.
- Reserve and write to the same index in the same cycle: the data is written and busy ends at 1. The new producer wins.
- Reserve and write to different indices: both take effect independently.
- Read, per port X in {a,b}, with idx = readnum_x and hit = BYPASS & write & (writenum==idx):
  - data_out_x = hit ? data_in : reg[idx].
  - busy_x = busy[idx] & ~hit. A bypassed value counts as available.
- Both ports may address the same register, or the write register, in the same cycle. Each port resolves independently using the rule above.
- ZERO_R0=1:
  - writes and reserves to index 0 are ignored;
  - data_out_x = 0 and busy_x = 0 whenever readnum_x = 0, including bypass cases.
- Reads have no unknown or default values. Every index is valid because NREGS = 2**ADDR_W.
- write=0 or reserve=0 leaves the corresponding state unchanged. Registers hold indefinitely.

Decomposition:
- Package regfile_pkg:
  - default DATA_W and ADDR_W constants;
  - register index type;
  - localparam NREGS.
- Sub-module rf_scoreboard (NREGS busy flops; set/clear/reset priority; two lookup ports):
  - owns the reserve-vs-write priority;
  - is instantiated once;
  - the data array and read muxes stay in the top module.
- The read mux is binary-indexed. There is no one-hot select and no decoder-to-mux path.

Test Plan:
- Reset then read all 8 indices on both ports -> data_out_a/b = 0x0000, busy_a/b = 0 for every index.
- Write 0xBEEF to R3, next cycle readnum_a=3, readnum_b=3 -> both ports read 0xBEEF. With BYPASS=1, readnum_a=3 in the write cycle itself shows 0xBEEF; with BYPASS=0 it shows 0x0000.
- Reserve R5, next cycle readnum_b=5 -> busy_b=1. Write 0x1234 to R5 -> busy_b=0 during that cycle with BYPASS=1, data_out_b=0x1234, and busy stays 0 afterwards.
- Same cycle reserve R2 and write 0x00AA to R2 -> next cycle data_out_a=0x00AA, busy_a=1.
- Write 0x5555 to R6 and R7, then assert reset together with write 0xFFFF to R6 -> next cycle R6=0x0000 and R7=0x0000, all busy=0.
- ZERO_R0=1: write 0x7777 to R0 and reserve R0 -> readnum_a=0 gives data_out_a=0x0000, busy_a=0 both in the write cycle and after it.
